cp0_intr_ctrl: RTL and testbench

//   CP0 exception/interrupt controller: the source side of the EPC register.
//   - Samples external IRQs and synchronous exception flags.
//   - Decides when to trap; drives Inta/Wepc/Mtc0_epc to the EPC block and Pc_sel to the PC mux.
//   - Holds Status and Cause; serves Mfc0/Mtc0.
//   - On Eret, returns to the EPC value.

---
 rtl/cp0_intr_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_cp0_intr_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_intr_ctrl.sv
// rtl/cp0_intr_ctrl.sv - CP0 exception/interrupt controller driving EPC write and PC select
module cp0_intr_ctrl #(
    parameter int          NUM_IRQ = 6,
    parameter logic [31:0] VECTOR  = 32'h0000_0008
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic [NUM_IRQ-1:0] Irq,
    input  logic               Syscall,
    input  logic               Unimpl,
    input  logic               Overflow,
    input  logic               Eret,
    input  logic               Mtc0,
    input  logic [4:0]         Rd,
    input  logic [31:0]        Wdata,
    input  logic [31:0]        Epc_in,
    output logic               Inta,
    output logic               Wepc,
    output logic               Mtc0_epc,
    output logic [1:0]         Pc_sel,
    output logic [31:0]        Vector,
    output logic [31:0]        Status,
    output logic [31:0]        Cause,
    output logic [31:0]        Rdata
);

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam logic [4:0] CODE_INT  = 5'd0;
    localparam logic [4:0] CODE_SYS  = 5'd8;
    localparam logic [4:0] CODE_RI   = 5'd10;
    localparam logic [4:0] CODE_OV   = 5'd12;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_VEC = 2'b01;
    localparam logic [1:0] PC_EPC = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               ie;
    logic [NUM_IRQ-1:0] im;
    logic [NUM_IRQ-1:0] ip;
    logic [4:0]         exc_code;
    logic               exl;

    logic               exc;
    logic [4:0]         exc_code_new;
    logic               int_req;

    logic               code_load;
    logic [4:0]         code_val;
    logic               mtc0_en;
    logic               epc_mtc0_ok;
    logic               status_wr;

    assign exl    = (state == ST_HANDLER);
    assign Vector = VECTOR;

    assign exc = Syscall | Unimpl | Overflow;

    // Unimplemented beats syscall beats overflow when several flags fire together
    always_comb begin
        exc_code_new = CODE_OV;
        if (Unimpl) begin
            exc_code_new = CODE_RI;
        end else if (Syscall) begin
            exc_code_new = CODE_SYS;
        end
    end

    // Interrupt request uses the Status value held before any same-cycle MTC0
    assign int_req = ie & ~exl & (|(ip & im));

    // Next-state and trap control outputs
    always_comb begin
        state_next  = state;
        Inta        = 1'b0;
        Wepc        = 1'b0;
        Mtc0_epc    = 1'b0;
        Pc_sel      = PC_SEQ;
        code_load   = 1'b0;
        code_val    = CODE_INT;
        mtc0_en     = Mtc0;
        epc_mtc0_ok = 1'b1;

        case (state)
            ST_RUN: begin
                if (exc) begin
                    // Faulting instruction does not commit, so its MTC0 is squashed
                    Pc_sel     = PC_VEC;
                    Wepc       = 1'b1;
                    code_load  = 1'b1;
                    code_val   = exc_code_new;
                    mtc0_en    = 1'b0;
                    state_next = ST_HANDLER;
                end else if (Eret) begin
                    // Interrupts wait until the returned-to instruction is running
                    Pc_sel = PC_EPC;
                end else if (int_req) begin
                    // EPC port is busy saving the return address, so an MTC0 to EPC is lost
                    Pc_sel      = PC_VEC;
                    Wepc        = 1'b1;
                    Inta        = 1'b1;
                    code_load   = 1'b1;
                    code_val    = CODE_INT;
                    epc_mtc0_ok = 1'b0;
                    state_next  = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (exc) begin
                    // Nested exception: re-enter the handler but keep the original EPC
                    Pc_sel    = PC_VEC;
                    code_load = 1'b1;
                    code_val  = exc_code_new;
                    mtc0_en   = 1'b0;
                end else if (Eret) begin
                    Pc_sel     = PC_EPC;
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (mtc0_en && epc_mtc0_ok && (Rd == REG_EPC)) begin
            Mtc0_epc = 1'b1;
            Wepc     = 1'b1;
            Inta     = 1'b0;
        end
    end

    assign status_wr = mtc0_en && (Rd == REG_STATUS);

    // State register; EXL is derived from it
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Software-writable Status fields
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            ie <= 1'b0;
            im <= '0;
        end else if (status_wr) begin
            ie <= Wdata[0];
            im <= Wdata[8 +: NUM_IRQ];
        end
    end

    // Cause: pending lines follow Irq every edge, ExcCode loads on a trap
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            ip       <= '0;
            exc_code <= CODE_INT;
        end else begin
            ip <= Irq;
            if (code_load) begin
                exc_code <= code_val;
            end
        end
    end

    // Assemble the architectural Status and Cause words
    always_comb begin
        Status              = '0;
        Status[0]           = ie;
        Status[1]           = exl;
        Status[8 +: NUM_IRQ] = im;
        Cause               = '0;
        Cause[6:2]          = exc_code;
        Cause[8 +: NUM_IRQ] = ip;
    end

    // MFC0 read mux
    always_comb begin
        Rdata = '0;
        case (Rd)
            REG_STATUS: Rdata = Status;
            REG_CAUSE:  Rdata = Cause;
            REG_EPC:    Rdata = Epc_in;
            default:    Rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intr_ctrl.sv
// tb/tb_cp0_intr_ctrl.sv - vector and scoreboard bench for cp0_intr_ctrl
`timescale 1ns/1ps
module tb_cp0_intr_ctrl;

    logic        Clk;
    logic        Clrn;
    logic [5:0]  Irq;
    logic        Syscall, Unimpl, Overflow, Eret, Mtc0;
    logic [4:0]  Rd;
    logic [31:0] Wdata, Epc_in;
    logic        Inta, Wepc, Mtc0_epc;
    logic [1:0]  Pc_sel;
    logic [31:0] Vector, Status, Cause, Rdata;

    int checks = 0;
    int errors = 0;

    cp0_intr_ctrl #(.NUM_IRQ(6), .VECTOR(32'h0000_0008)) dut (
        .Clk(Clk), .Clrn(Clrn), .Irq(Irq), .Syscall(Syscall), .Unimpl(Unimpl),
        .Overflow(Overflow), .Eret(Eret), .Mtc0(Mtc0), .Rd(Rd), .Wdata(Wdata),
        .Epc_in(Epc_in), .Inta(Inta), .Wepc(Wepc), .Mtc0_epc(Mtc0_epc),
        .Pc_sel(Pc_sel), .Vector(Vector), .Status(Status), .Cause(Cause), .Rdata(Rdata)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ctl = {Inta, Wepc, Mtc0_epc, Pc_sel}
    typedef struct {
        logic [5:0]  irq;
        logic        sys, uni, ovf, eret, mtc0;
        logic [4:0]  rd;
        logic [31:0] wdata, epc;
        logic [4:0]  ctl;
        logic [31:0] st, ca, rdat;
    } vec_t;

    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] st, ca, rdat;
    } exp_t;

    vec_t vt[18];
    exp_t sb[$];

    function automatic vec_t mk(logic [5:0] irq, logic sys, logic uni, logic ovf,
                                logic eret, logic mtc0, logic [4:0] rd,
                                logic [31:0] wdata, logic [31:0] epc, logic [4:0] ctl,
                                logic [31:0] st, logic [31:0] ca, logic [31:0] rdat);
        vec_t v;
        v.irq = irq; v.sys = sys; v.uni = uni; v.ovf = ovf; v.eret = eret; v.mtc0 = mtc0;
        v.rd = rd; v.wdata = wdata; v.epc = epc;
        v.ctl = ctl; v.st = st; v.ca = ca; v.rdat = rdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        Irq = v.irq; Syscall = v.sys; Unimpl = v.uni; Overflow = v.ovf;
        Eret = v.eret; Mtc0 = v.mtc0; Rd = v.rd; Wdata = v.wdata; Epc_in = v.epc;
    endtask

    task automatic idle(input logic [5:0] irq, input logic [4:0] rd);
        drive(mk(irq, 0, 0, 0, 0, 0, rd, 32'h0, 32'h0, 5'b0, 32'h0, 32'h0, 32'h0));
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ctl"},   {27'h0, Inta, Wepc, Mtc0_epc, Pc_sel}, {27'h0, e.ctl});
            chk({tag, "_status"}, Status, e.st);
            chk({tag, "_cause"},  Cause,  e.ca);
            chk({tag, "_rdata"},  Rdata,  e.rdat);
        end
    endtask

    initial begin
        exp_t e;
        //          irq    sys uni ovf eret mtc0 rd     wdata         epc           ctl       status      cause       rdata
        vt[0]  = mk(6'h04, 0, 0, 0, 0, 0, 5'd13, 32'h0,        32'h0,        5'b00000, 32'h000, 32'h000, 32'h000);
        vt[1]  = mk(6'h04, 0, 0, 0, 0, 0, 5'd13, 32'h0,        32'h0,        5'b00000, 32'h000, 32'h400, 32'h400);
        vt[2]  = mk(6'h04, 0, 0, 0, 0, 1, 5'd12, 32'h401,      32'h0,        5'b00000, 32'h000, 32'h400, 32'h000);
        vt[3]  = mk(6'h04, 0, 0, 0, 0, 0, 5'd12, 32'h0,        32'h0,        5'b11001, 32'h401, 32'h400, 32'h401);
        vt[4]  = mk(6'h04, 0, 0, 0, 0, 0, 5'd12, 32'h0,        32'h0,        5'b00000, 32'h403, 32'h400, 32'h403);
        vt[5]  = mk(6'h04, 0, 0, 1, 0, 0, 5'd13, 32'h0,        32'h0,        5'b00001, 32'h403, 32'h400, 32'h400);
        vt[6]  = mk(6'h04, 0, 0, 0, 0, 0, 5'd13, 32'h0,        32'h0,        5'b00000, 32'h403, 32'h430, 32'h430);
        vt[7]  = mk(6'h04, 0, 0, 0, 1, 0, 5'd14, 32'h0,        32'h00400020, 5'b00010, 32'h403, 32'h430, 32'h00400020);
        vt[8]  = mk(6'h04, 0, 0, 0, 0, 0, 5'd12, 32'h0,        32'h0,        5'b11001, 32'h401, 32'h430, 32'h401);
        vt[9]  = mk(6'h04, 0, 0, 0, 1, 0, 5'd12, 32'h0,        32'h0,        5'b00010, 32'h403, 32'h400, 32'h403);
        vt[10] = mk(6'h04, 1, 0, 0, 0, 0, 5'd13, 32'h0,        32'h0,        5'b01001, 32'h401, 32'h400, 32'h400);
        vt[11] = mk(6'h04, 0, 0, 0, 0, 0, 5'd12, 32'h0,        32'h0,        5'b00000, 32'h403, 32'h420, 32'h403);
        vt[12] = mk(6'h04, 0, 0, 0, 1, 0, 5'd13, 32'h0,        32'h0,        5'b00010, 32'h403, 32'h420, 32'h420);
        vt[13] = mk(6'h04, 0, 0, 0, 1, 0, 5'd13, 32'h0,        32'h0,        5'b00010, 32'h401, 32'h420, 32'h420);
        vt[14] = mk(6'h04, 0, 0, 0, 0, 1, 5'd14, 32'h1234,     32'h0,        5'b11001, 32'h401, 32'h420, 32'h000);
        vt[15] = mk(6'h00, 0, 0, 0, 0, 1, 5'd14, 32'h1234,     32'h00400020, 5'b01100, 32'h403, 32'h400, 32'h00400020);
        vt[16] = mk(6'h00, 1, 1, 0, 0, 1, 5'd12, 32'h0,        32'h0,        5'b00001, 32'h403, 32'h000, 32'h403);
        vt[17] = mk(6'h00, 0, 0, 0, 0, 0, 5'd12, 32'h0,        32'h0,        5'b00000, 32'h403, 32'h028, 32'h403);

        Clrn = 1'b0;
        idle(6'h00, 5'd0);

        // reset state, held across an edge
        @(negedge Clk);
        @(negedge Clk);
        chk("reset_ctl", {27'h0, Inta, Wepc, Mtc0_epc, Pc_sel}, 32'h0);
        chk("reset_status", Status, 32'h0);
        chk("reset_cause", Cause, 32'h0);
        chk("vector", Vector, 32'h0000_0008);
        Clrn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(posedge Clk);
            #1;
            drive(vt[i]);
            e.ctl = vt[i].ctl; e.st = vt[i].st; e.ca = vt[i].ca; e.rdat = vt[i].rdat;
            sb.push_back(e);
            @(negedge Clk);
            pop_check($sformatf("vec%0d", i));
        end

        // asynchronous reset in the middle of a handler
        @(posedge Clk);
        #1;
        idle(6'h04, 5'd12);
        @(negedge Clk);
        chk("pre_reset_status", Status, 32'h403);
        #2;
        Clrn = 1'b0;
        #1;
        chk("async_reset_status", Status, 32'h0);
        chk("async_reset_cause", Cause, 32'h0);
        chk("async_reset_ctl", {27'h0, Inta, Wepc, Mtc0_epc, Pc_sel}, 32'h0);
        @(negedge Clk);
        Clrn = 1'b1;
        @(posedge Clk);
        #1;
        chk("resample_cause", Cause, 32'h400);
        chk("resample_status", Status, 32'h0);
        chk("resample_inta", {31'h0, Inta}, 32'h0);

        // interrupt taken while an MTC0 to Status in the same instruction still lands
        Mtc0 = 1'b1; Rd = 5'd12; Wdata = 32'h401;
        @(posedge Clk);
        #1;
        Wdata = 32'h801;
        @(negedge Clk);
        chk("int_mtc0_ctl", {27'h0, Inta, Wepc, Mtc0_epc, Pc_sel}, {27'h0, 5'b11001});
        @(posedge Clk);
        #1;
        idle(6'h04, 5'd12);
        chk("int_mtc0_status", Status, 32'h803);
        chk("int_mtc0_cause", Cause, 32'h400);

        // overflow alone in RUN after leaving the handler
        Eret = 1'b1;
        @(posedge Clk);
        #1;
        idle(6'h00, 5'd13);
        Overflow = 1'b1;
        @(negedge Clk);
        chk("run_ovf_ctl", {27'h0, Inta, Wepc, Mtc0_epc, Pc_sel}, {27'h0, 5'b01001});
        @(posedge Clk);
        #1;
        idle(6'h00, 5'd13);
        chk("run_ovf_cause", Cause, 32'h030);
        chk("run_ovf_status", Status, 32'h803);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
